// File: rtl/node_tx_arbiter.sv
// Round-robin arbiter sharing one router node-side transmit port among NUM_REQ requesters.
// Optional send watchdog enabled by defining NODE_TX_TIMEOUT_EN (pulses Req_Err on expiry).
module node_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 4,
   parameter int DATA_W  = 24,
   parameter int TIMEOUT = 1023,
   localparam int PKT_W  = ADDR_W + 1 + DATA_W,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                     Clk_R,
   input  logic                     Rst,
   input  logic [NUM_REQ-1:0]       Req_Valid,
   input  logic [NUM_REQ*PKT_W-1:0] Req_Packet,
   output logic [NUM_REQ-1:0]       Req_Ack,
   output logic [NUM_REQ-1:0]       Req_Err,
   output logic [PKT_W-1:0]         Packet_From_Node,
   output logic                     Packet_From_Node_Valid,
   input  logic                     Core_Load_Ack,
   output logic [ID_W-1:0]          Grant_Id,
   output logic                     Busy
);

   // Handshake: Packet_From_Node_Valid rises with a frozen packet and stays high until
   // Core_Load_Ack is sampled high; valid then drops and the FSM waits for the ack to go
   // low before arbitrating again, giving the router a valid-low gap of at least 2 cycles.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_LOW = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]      grant_q, grant_d;
   logic [PKT_W-1:0]     pkt_q, pkt_d;
   logic                 valid_q, valid_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;

   logic                 win_found;
   logic [ID_W-1:0]      win_id;
   int                   cand;

`ifdef NODE_TX_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   err_q, err_d;
`endif

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = int'(rr_ptr_q) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!win_found && Req_Valid[ID_W'(cand)]) begin
            win_found = 1'b1;
            win_id    = ID_W'(cand);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      pkt_d    = pkt_q;
      valid_d  = valid_q;
      ack_d    = '0;
`ifdef NODE_TX_TIMEOUT_EN
      cnt_d    = cnt_q;
      err_d    = '0;
`endif
      case (state_q)
         IDLE: begin
            // A high ack here is stale; granting would let the router see a bogus load.
            if (win_found && !Core_Load_Ack) begin
               grant_d  = win_id;
               rr_ptr_d = win_id;
               pkt_d    = Req_Packet[int'(win_id)*PKT_W +: PKT_W];
               valid_d  = 1'b1;
               state_d  = SEND;
`ifdef NODE_TX_TIMEOUT_EN
               cnt_d    = '0;
`endif
            end
         end
         SEND: begin
            if (Core_Load_Ack) begin
               valid_d = 1'b0;
               ack_d   = NUM_REQ'(1) << grant_q;
               state_d = WAIT_LOW;
            end
`ifdef NODE_TX_TIMEOUT_EN
            else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               valid_d = 1'b0;
               err_d   = NUM_REQ'(1) << grant_q;
               state_d = WAIT_LOW;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         WAIT_LOW: begin
            if (!Core_Load_Ack) state_d = IDLE;
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk_R or posedge Rst) begin
      if (Rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= ID_W'(NUM_REQ - 1);
         grant_q  <= '0;
         pkt_q    <= '0;
         valid_q  <= 1'b0;
         ack_q    <= '0;
`ifdef NODE_TX_TIMEOUT_EN
         cnt_q    <= '0;
         err_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         pkt_q    <= pkt_d;
         valid_q  <= valid_d;
         ack_q    <= ack_d;
`ifdef NODE_TX_TIMEOUT_EN
         cnt_q    <= cnt_d;
         err_q    <= err_d;
`endif
      end
   end

   assign Req_Ack                = ack_q;
   assign Packet_From_Node       = pkt_q;
   assign Packet_From_Node_Valid = valid_q;
   assign Grant_Id               = grant_q;
   assign Busy                   = (state_q != IDLE);

`ifdef NODE_TX_TIMEOUT_EN
   assign Req_Err = err_q;
`else
   assign Req_Err = '0;
`endif

endmodule
